// File: rtl/mbssoc_ram_arbiter_pkg.sv
// Shared MBScore constants plus arbiter state encodings and hold-counter width.
// ADDR_WIDTH may be overridden by defining the ADDR_WIDTH macro before compilation.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package mbssoc_ram_arbiter_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int CORE_NUM   = 2;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  localparam int HOLD_W = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbssoc_rr_pick.sv
// Combinational round-robin winner search starting at ptr+1 modulo N_REQ.
module mbssoc_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= unsigned'(N_REQ); k++) begin
      cand = IW'((32'(ptr) + k) % unsigned'(N_REQ));
      if (!win_vld && req[cand]) begin
        win_vld       = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbssoc_ram_arbiter.sv
// Round-robin single-port RAM arbiter (IDLE/GRANT FSM, registered one-hot grant).
// Define MBSSOC_ARB_TIMEOUT_EN to enable forced release after HOLD_MAX cycles and the timeout pulse.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mbssoc_ram_arbiter
  import mbssoc_ram_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = `ADDR_WIDTH,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  we,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  pause,
  output logic              ram_re,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic              busy
`ifdef MBSSOC_ARB_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int IW = idx_width(N_REQ);

  logic [0:0]        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N_REQ-1:0]  win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_vld;

  logic              own_req, own_we, hold_sat, force_rel, active;
  logic [AW-1:0]     own_addr;

  mbssoc_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // ptr_q holds the owner index for the whole grant, so it doubles as the mux select
  assign own_req = req[ptr_q];
  assign own_we  = we[ptr_q];

  always_comb begin
    own_addr = '0;
    for (int unsigned i = 0; i < unsigned'(N_REQ); i++) begin
      if (IW'(i) == ptr_q) own_addr = addr[i*AW +: AW];
    end
  end

  assign hold_sat = (hold_q >= HOLD_W'(HOLD_MAX - 1));

`ifdef MBSSOC_ARB_TIMEOUT_EN
  assign force_rel = hold_sat && |(req & ~gnt_q);
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          state_d = ARB_GRANT;
          gnt_d   = win_oh;
          ptr_d   = win_idx;
          hold_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (!own_req || force_rel) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (!hold_sat) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

`ifdef MBSSOC_ARB_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= (state_q == ARB_GRANT) && own_req && force_rel;
  end

  assign timeout = timeout_q;
`endif

  // Gated by rst so strobes stay quiet even before the reset edge lands mid-grant
  assign active   = (state_q == ARB_GRANT) && !rst;
  assign busy     = active;
  assign gnt      = gnt_q;
  assign pause    = req & ~gnt_q;
  assign ram_re   = active && own_req && !own_we;
  assign ram_we   = active && own_req && own_we;
  assign ram_addr = active ? own_addr : '0;

endmodule

// File: tb/tb_mbssoc_ram_arbiter.sv
// Table-driven bench for mbssoc_ram_arbiter (N_REQ=2, AW=16, HOLD_MAX=4) plus a hold/timeout sequence.
module tb_mbssoc_ram_arbiter;

  typedef struct packed {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  gnt;
    logic [1:0]  pause;
    logic        re;
    logic        wr;
    logic [15:0] addr;
    logic        busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr;
  logic [1:0]  gnt, pause;
  logic        ram_re, ram_we, busy;
  logic [15:0] ram_addr;
`ifdef MBSSOC_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mbssoc_ram_arbiter #(
    .N_REQ    (2),
    .AW       (16),
    .HOLD_MAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .gnt      (gnt),
    .pause    (pause),
    .ram_re   (ram_re),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .busy     (busy)
`ifdef MBSSOC_ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] w,
                     input logic [15:0] x0, input logic [15:0] x1,
                     input logic [1:0] g, input logic [1:0] p, input logic e_re,
                     input logic e_wr, input logic [15:0] e_addr, input logic e_busy);
    vecs.push_back({r, rq, w, x0, x1, g, p, e_re, e_wr, e_addr, e_busy});
  endtask

  task automatic drive_edge(input logic r, input logic [1:0] rq, input logic [1:0] w,
                            input logic [15:0] x0, input logic [15:0] x1);
    @(negedge clk);
    rst  = r;
    req  = rq;
    we   = w;
    addr = {x1, x0};
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int step, input logic [1:0] g, input logic [1:0] p,
                          input logic e_re, input logic e_wr, input logic [15:0] e_addr, input logic e_busy);
    chk({tag, "_gnt"},   step, 32'(gnt),      32'(g));
    chk({tag, "_pause"}, step, 32'(pause),    32'(p));
    chk({tag, "_re"},    step, 32'(ram_re),   32'(e_re));
    chk({tag, "_we"},    step, 32'(ram_we),   32'(e_wr));
    chk({tag, "_addr"},  step, 32'(ram_addr), 32'(e_addr));
    chk({tag, "_busy"},  step, 32'(busy),     32'(e_busy));
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0;

    //  rst req    we     a0       a1       gnt    pause  re wr addr     busy
    add(1, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(1, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b11, 0, 0, 16'h0000, 0);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b10, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b10, 0, 0, 16'h0000, 0);
    add(0, 2'b10, 2'b00, 16'h1111, 16'h2222, 2'b10, 2'b00, 1, 0, 16'h2222, 1);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(0, 2'b01, 2'b01, 16'h0040, 16'h2222, 2'b01, 2'b00, 0, 1, 16'h0040, 1);
    add(0, 2'b01, 2'b01, 16'h0040, 16'h2222, 2'b01, 2'b00, 0, 1, 16'h0040, 1);
    add(0, 2'b01, 2'b01, 16'h0040, 16'h2222, 2'b01, 2'b00, 0, 1, 16'h0040, 1);
    add(0, 2'b01, 2'b01, 16'h0040, 16'h2222, 2'b01, 2'b00, 0, 1, 16'h0040, 1);
    add(0, 2'b01, 2'b01, 16'h0040, 16'h2222, 2'b01, 2'b00, 0, 1, 16'h0040, 1);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(0, 2'b01, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b00, 1, 0, 16'h1111, 1);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b01, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b00, 1, 0, 16'h1111, 1);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);
    add(0, 2'b10, 2'b00, 16'h1111, 16'h2222, 2'b10, 2'b00, 1, 0, 16'h2222, 1);
    add(1, 2'b10, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b10, 0, 0, 16'h0000, 0);
    add(0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b01, 2'b10, 1, 0, 16'h1111, 1);
    add(0, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b00, 2'b00, 0, 0, 16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_edge(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1);
      chk_outs("vec", i, vecs[i].gnt, vecs[i].pause, vecs[i].re, vecs[i].wr, vecs[i].addr, vecs[i].busy);
`ifdef MBSSOC_ARB_TIMEOUT_EN
      chk("vec_timeout", i, 32'(timeout), 32'd0);
`endif
    end

    // Core0 takes the grant alone (ptr=0 after the last table grant), then core1 competes.
    drive_edge(0, 2'b01, 2'b00, 16'h00A0, 16'h00B0);
    chk_outs("hold", 100, 2'b01, 2'b00, 1, 0, 16'h00A0, 1);
    for (int c = 0; c < 3; c++) begin
      drive_edge(0, 2'b11, 2'b00, 16'h00A0, 16'h00B0);
      chk_outs("hold", 101 + c, 2'b01, 2'b10, 1, 0, 16'h00A0, 1);
`ifdef MBSSOC_ARB_TIMEOUT_EN
      chk("hold_timeout", 101 + c, 32'(timeout), 32'd0);
`endif
    end
    drive_edge(0, 2'b11, 2'b00, 16'h00A0, 16'h00B0);
`ifdef MBSSOC_ARB_TIMEOUT_EN
    chk_outs("release", 104, 2'b00, 2'b11, 0, 0, 16'h0000, 0);
    chk("release_timeout", 104, 32'(timeout), 32'd1);
    drive_edge(0, 2'b11, 2'b00, 16'h00A0, 16'h00B0);
    chk_outs("regrant", 105, 2'b10, 2'b01, 1, 0, 16'h00B0, 1);
    chk("regrant_timeout", 105, 32'(timeout), 32'd0);
`else
    chk_outs("keep", 104, 2'b01, 2'b10, 1, 0, 16'h00A0, 1);
    for (int c = 0; c < 4; c++) begin
      drive_edge(0, 2'b11, 2'b00, 16'h00A0, 16'h00B0);
      chk_outs("keep", 105 + c, 2'b01, 2'b10, 1, 0, 16'h00A0, 1);
    end
`endif
    drive_edge(0, 2'b00, 2'b00, 16'h00A0, 16'h00B0);
    chk_outs("drain", 110, 2'b00, 2'b00, 0, 0, 16'h0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
